// File: rtl/out_port_arb_if.sv
// Handshake bundle between the input side of the router and one output-port allocator.
// The master side drives requests, flit qualifiers and credits; the slave side is the arbiter.
interface out_port_arb_if #(
    parameter int unsigned PORTS = 6
) ();
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] ivalid;
    logic [PORTS-1:0] itail;
    logic             credit_ret;
    logic [PORTS-1:0] sel;
    logic [PORTS-1:0] iready;
    logic             fire;
    logic             busy;
    logic             credit_err;

    modport master (
        output req, ivalid, itail, credit_ret,
        input  sel, iready, fire, busy, credit_err
    );

    modport slave (
        input  req, ivalid, itail, credit_ret,
        output sel, iready, fire, busy, credit_err
    );
endinterface

// File: rtl/out_port_arb.sv
// Per-output-port wormhole switch allocator: round-robin grant per packet, held head to tail,
// with downstream credit tracking gating each flit transfer.
module out_port_arb #(
    parameter int unsigned PORTS   = 6,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNTW    = 3
) (
    input logic           clk,
    input logic           rst_,
    out_port_arb_if.slave bus
);
    localparam int unsigned     PTRW    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(CREDITS);
    localparam logic [PTRW-1:0] LAST    = PTRW'(PORTS - 1);
    localparam logic [PORTS-1:0] ONE    = {{(PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e           state_q, state_d;
    logic [PORTS-1:0] sel_q, sel_d;
    logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0]  gidx_q, gidx_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             credit_err_q, credit_err_d;

    logic             has_credit;
    logic             fire;
    logic             tail_fire;
    logic [PORTS-1:0] iready;
    logic             pick_found;
    logic [PTRW-1:0]  pick_idx;

    // First requester at or after rr_ptr, wrapping over all ports.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            idx = (32'(rr_ptr_q) + k) % PORTS;
            if (!pick_found && bus.req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTRW'(idx);
            end
        end
    end

    assign has_credit = (cnt_q != '0);
    assign iready     = sel_q & bus.ivalid & {PORTS{has_credit}};
    assign fire       = |iready;
    assign tail_fire  = |(iready & bus.itail);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StLock;
                    sel_d   = ONE << pick_idx;
                    gidx_d  = pick_idx;
                end
            end
            StLock: begin
                // Only the tail releases the lock; req of the owner is not looked at here.
                if (tail_fire) begin
                    state_d  = StIdle;
                    sel_d    = '0;
                    rr_ptr_d = (gidx_q == LAST) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        credit_err_d = credit_err_q;
        case ({fire, bus.credit_ret})
            2'b10: cnt_d = cnt_q - 1'b1;
            2'b01: begin
                if (cnt_q == CNT_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            rr_ptr_q     <= '0;
            gidx_q       <= '0;
            cnt_q        <= CNT_MAX;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            gidx_q       <= gidx_d;
            cnt_q        <= cnt_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.iready     = iready;
    assign bus.fire       = fire;
    assign bus.busy       = (state_q == StLock);
    assign bus.credit_err = credit_err_q;
endmodule

// File: tb/tb_out_port_arb.sv
// Directed bench for out_port_arb: reset, round-robin, wormhole lock, credit flow and lone requester.
module tb_out_port_arb;
    logic clk;
    logic rst_;
    int   n_checks;
    int   n_errors;

    out_port_arb_if #(.PORTS(6)) bus ();

    out_port_arb #(
        .PORTS  (6),
        .CREDITS(4),
        .CNTW   (3)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_           = 1'b0;
        bus.req        = '0;
        bus.ivalid     = '0;
        bus.itail      = '0;
        bus.credit_ret = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_ = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        int n;
        apply_reset();
        n_checks++;
        if (bus.sel !== 6'b0 || bus.busy !== 1'b0 || bus.fire !== 1'b0 ||
            bus.iready !== 6'b0 || bus.credit_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: sel=%b busy=%b fire=%b iready=%b err=%b, want all 0",
                     bus.sel, bus.busy, bus.fire, bus.iready, bus.credit_err);
        end
        // Set credit_err, then build a lock down to cnt=1.
        bus.credit_ret = 1'b1;
        cyc();
        bus.credit_ret = 1'b0;
        bus.req        = 6'b000001;
        bus.ivalid     = 6'b000001;
        cyc();
        cyc();
        cyc();
        cyc();
        n_checks++;
        if (bus.fire !== 1'b1 || bus.busy !== 1'b1 || bus.credit_err !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_prelock: fire=%b busy=%b err=%b, want 1 1 1",
                     bus.fire, bus.busy, bus.credit_err);
        end
        #2;
        rst_ = 1'b0;
        #1;
        n_checks++;
        if (bus.sel !== 6'b0 || bus.busy !== 1'b0 || bus.fire !== 1'b0 ||
            bus.credit_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: sel=%b busy=%b fire=%b err=%b, want 0 0 0 0",
                     bus.sel, bus.busy, bus.fire, bus.credit_err);
        end
        rst_ = 1'b1;
        n = 0;
        repeat (10) begin
            cyc();
            if (bus.fire === 1'b1) n++;
        end
        n_checks++;
        if (n !== 4) begin
            n_errors++;
            $display("FAIL reset_credits: fires=%0d, want 4", n);
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] exp_sel [4];
        exp_sel[0] = 6'b000001;
        exp_sel[1] = 6'b000100;
        exp_sel[2] = 6'b100000;
        exp_sel[3] = 6'b000001;
        apply_reset();
        bus.req    = 6'b100101;
        bus.ivalid = 6'b100101;
        bus.itail  = 6'b111111;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.sel !== exp_sel[i] || bus.fire !== 1'b1) begin
                n_errors++;
                $display("FAIL rr_grant%0d: sel=%b fire=%b, want %b 1",
                         i, bus.sel, bus.fire, exp_sel[i]);
            end
            cyc();
            n_checks++;
            if (bus.sel !== 6'b0 || bus.busy !== 1'b0) begin
                n_errors++;
                $display("FAIL rr_bubble%0d: sel=%b busy=%b, want 0 0", i, bus.sel, bus.busy);
            end
        end
    endtask

    task automatic test_wormhole();
        apply_reset();
        bus.req    = 6'b000010;
        bus.ivalid = 6'b000010;
        cyc();
        n_checks++;
        if (bus.sel !== 6'b000010 || bus.fire !== 1'b1) begin
            n_errors++;
            $display("FAIL worm_head: sel=%b fire=%b, want 000010 1", bus.sel, bus.fire);
        end
        cyc();
        // Owner drops req mid-packet while port3 asks with a tail-flagged flit.
        bus.req    = 6'b001000;
        bus.ivalid = 6'b001010;
        bus.itail  = 6'b001000;
        #1;
        n_checks++;
        if (bus.sel !== 6'b000010 || bus.iready !== 6'b000010) begin
            n_errors++;
            $display("FAIL worm_body: sel=%b iready=%b, want 000010 000010", bus.sel, bus.iready);
        end
        cyc();
        bus.itail = 6'b001010;
        #1;
        n_checks++;
        if (bus.sel !== 6'b000010 || bus.fire !== 1'b1) begin
            n_errors++;
            $display("FAIL worm_tail: sel=%b fire=%b, want 000010 1", bus.sel, bus.fire);
        end
        cyc();
        bus.ivalid = 6'b001000;
        bus.itail  = 6'b001000;
        #1;
        n_checks++;
        if (bus.sel !== 6'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL worm_idle: sel=%b busy=%b, want 0 0", bus.sel, bus.busy);
        end
        cyc();
        n_checks++;
        if (bus.sel !== 6'b001000 || bus.fire !== 1'b1) begin
            n_errors++;
            $display("FAIL worm_next: sel=%b fire=%b, want 001000 1", bus.sel, bus.fire);
        end
    endtask

    task automatic test_credit_stall();
        int n;
        apply_reset();
        bus.req    = 6'b010000;
        bus.ivalid = 6'b010000;
        cyc();
        n = 0;
        repeat (8) begin
            if (bus.fire === 1'b1) n++;
            cyc();
        end
        n_checks++;
        if (n !== 4) begin
            n_errors++;
            $display("FAIL stall_fires: fires=%0d, want 4", n);
        end
        n_checks++;
        if (bus.sel !== 6'b010000 || bus.fire !== 1'b0 || bus.iready !== 6'b0) begin
            n_errors++;
            $display("FAIL stall_hold: sel=%b fire=%b iready=%b, want 010000 0 000000",
                     bus.sel, bus.fire, bus.iready);
        end
        bus.credit_ret = 1'b1;
        cyc();
        bus.credit_ret = 1'b0;
        #1;
        n = 0;
        repeat (5) begin
            if (bus.fire === 1'b1) n++;
            cyc();
        end
        n_checks++;
        if (n !== 1) begin
            n_errors++;
            $display("FAIL stall_one_credit: fires=%0d, want 1", n);
        end
    endtask

    task automatic test_credit_count();
        int n;
        apply_reset();
        bus.req    = 6'b000001;
        bus.ivalid = 6'b000001;
        cyc();
        cyc();
        cyc();
        bus.credit_ret = 1'b1;
        #1;
        n_checks++;
        if (bus.fire !== 1'b1) begin
            n_errors++;
            $display("FAIL cnt_pre: fire=%b, want 1", bus.fire);
        end
        cyc();
        bus.credit_ret = 1'b0;
        #1;
        n = 0;
        repeat (6) begin
            if (bus.fire === 1'b1) n++;
            cyc();
        end
        n_checks++;
        if (n !== 2 || bus.credit_err !== 1'b0) begin
            n_errors++;
            $display("FAIL cnt_simul: fires=%0d err=%b, want 2 0", n, bus.credit_err);
        end
        apply_reset();
        bus.credit_ret = 1'b1;
        cyc();
        bus.credit_ret = 1'b0;
        #1;
        n_checks++;
        if (bus.credit_err !== 1'b1) begin
            n_errors++;
            $display("FAIL cnt_err_set: err=%b, want 1", bus.credit_err);
        end
        repeat (3) cyc();
        bus.req    = 6'b000001;
        bus.ivalid = 6'b000001;
        cyc();
        n = 0;
        repeat (8) begin
            if (bus.fire === 1'b1) n++;
            cyc();
        end
        n_checks++;
        if (n !== 4 || bus.credit_err !== 1'b1) begin
            n_errors++;
            $display("FAIL cnt_saturate: fires=%0d err=%b, want 4 1", n, bus.credit_err);
        end
    endtask

    task automatic test_lone_requester();
        apply_reset();
        bus.req    = 6'b000100;
        bus.ivalid = 6'b000100;
        bus.itail  = 6'b000100;
        cyc();
        n_checks++;
        if (bus.sel !== 6'b000100 || bus.fire !== 1'b1) begin
            n_errors++;
            $display("FAIL lone_first: sel=%b fire=%b, want 000100 1", bus.sel, bus.fire);
        end
        cyc();
        n_checks++;
        if (bus.sel !== 6'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL lone_bubble: sel=%b busy=%b, want 0 0", bus.sel, bus.busy);
        end
        cyc();
        n_checks++;
        if (bus.sel !== 6'b000100 || bus.fire !== 1'b1) begin
            n_errors++;
            $display("FAIL lone_second: sel=%b fire=%b, want 000100 1", bus.sel, bus.fire);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_round_robin();
        test_wormhole();
        test_credit_stall();
        test_credit_count();
        test_lone_requester();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
